// File: rtl/load_align_unit_if.sv
// Request, beat-bus and response signals of load_align_unit.
// req_msize encoding: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 8 bytes.
interface load_align_unit_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_msize;
  logic              req_unsigned;
  logic              bus_valid;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ok;
  logic [DATA_W-1:0] bus_data;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_error;

  modport slave (
    input  req_valid, req_addr, req_msize, req_unsigned, bus_ok, bus_data,
    output req_ready, bus_valid, bus_addr, resp_valid, resp_data, resp_error
  );

  modport master (
    output req_valid, req_addr, req_msize, req_unsigned, bus_ok, bus_data,
    input  req_ready, bus_valid, bus_addr, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/load_align_unit.sv
// Load alignment unit: one load at a time, aligned beat fetch, byte extract and extend.
// Build option LOAD_SPLIT_EN: beat-crossing misaligned loads use two beats instead of ERR.
//
// state  | meaning
// IDLE   | ready for a request
// BEAT0  | single aligned beat outstanding
// SPLIT0 | first beat of a beat-crossing load (LOAD_SPLIT_EN)
// SPLIT1 | second beat, next beat address (LOAD_SPLIT_EN)
// DONE   | result pulse
// ERR    | misaligned-access error pulse
module load_align_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input logic clk,
  input logic reset,
  load_align_unit_if.slave lsu
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DATA_W);

`ifdef LOAD_SPLIT_EN
  typedef enum logic [2:0] {IDLE, BEAT0, DONE, ERR, SPLIT0, SPLIT1} state_t;
`else
  typedef enum logic [1:0] {IDLE, BEAT0, DONE, ERR} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        msize_q;
  logic              uns_q;
  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] beat_addr;
  logic [OFF_W-1:0]  off_q;
  logic [OFF_W-1:0]  req_off;
  int                req_bytes;
  logic              size_bad;
  logic              req_ready;
  logic              bus_valid;
  logic [ADDR_W-1:0] bus_addr;
  logic              resp_valid;
  logic              resp_error;
`ifdef LOAD_SPLIT_EN
  logic              req_cross;
  logic [DATA_W-1:0] hold_q;
`else
  logic              req_misalign;
`endif

  // Keep the low 8<<msize bits of raw and fill the rest with zeros or the sign bit.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [1:0] msize,
                                               input logic uns);
    int                nbits;
    logic [DATA_W-1:0] mask;
    logic              sign;
    nbits = 8 << msize;
    if (nbits >= DATA_W) begin
      mask = '1;
      sign = 1'b0;
    end else begin
      mask = (DATA_W'(1) << nbits) - DATA_W'(1);
      sign = raw[IDX_W'(nbits - 1)];
    end
    return (raw & mask) | ((sign && !uns) ? ~mask : '0);
  endfunction

  assign off_q     = addr_q[OFF_W-1:0];
  assign beat_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_off   = lsu.req_addr[OFF_W-1:0];
  assign req_bytes = 1 << lsu.req_msize;
  // An 8-byte access on a 32-bit bus can never be served.
  assign size_bad  = req_bytes > NB;
`ifdef LOAD_SPLIT_EN
  assign req_cross = (int'(req_off) + req_bytes) > NB;
`else
  assign req_misalign = ((int'(req_off) & (req_bytes - 1)) != 0) || size_bad;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    bus_valid  = 1'b0;
    bus_addr   = '0;
    resp_valid = 1'b0;
    resp_error = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (lsu.req_valid) begin
`ifdef LOAD_SPLIT_EN
          if (size_bad)       state_nxt = ERR;
          else if (req_cross) state_nxt = SPLIT0;
          else                state_nxt = BEAT0;
`else
          state_nxt = req_misalign ? ERR : BEAT0;
`endif
        end
      end
      BEAT0: begin
        bus_valid = 1'b1;
        bus_addr  = beat_addr;
        if (lsu.bus_ok) state_nxt = DONE;
      end
`ifdef LOAD_SPLIT_EN
      SPLIT0: begin
        bus_valid = 1'b1;
        bus_addr  = beat_addr;
        if (lsu.bus_ok) state_nxt = SPLIT1;
      end
      SPLIT1: begin
        bus_valid = 1'b1;
        bus_addr  = beat_addr + ADDR_W'(NB);
        if (lsu.bus_ok) state_nxt = DONE;
      end
`endif
      DONE: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_error = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      msize_q  <= '0;
      uns_q    <= 1'b0;
      result_q <= '0;
`ifdef LOAD_SPLIT_EN
      hold_q   <= '0;
`endif
    end else begin
      if (state == IDLE && lsu.req_valid) begin
        addr_q  <= lsu.req_addr;
        msize_q <= lsu.req_msize;
        uns_q   <= lsu.req_unsigned;
      end
      if (state == IDLE && state_nxt == ERR) result_q <= '0;
      if (state == BEAT0 && lsu.bus_ok)
        result_q <= extend(lsu.bus_data >> (int'(off_q) * 8), msize_q, uns_q);
`ifdef LOAD_SPLIT_EN
      // Low part from beat0 bytes [off..], high part from beat1 bytes [0..].
      if (state == SPLIT0 && lsu.bus_ok)
        hold_q <= lsu.bus_data >> (int'(off_q) * 8);
      if (state == SPLIT1 && lsu.bus_ok)
        result_q <= extend(hold_q | (lsu.bus_data << ((NB - int'(off_q)) * 8)),
                           msize_q, uns_q);
`endif
    end
  end

  assign lsu.req_ready  = req_ready;
  assign lsu.bus_valid  = bus_valid;
  assign lsu.bus_addr   = bus_addr;
  assign lsu.resp_valid = resp_valid;
  assign lsu.resp_data  = result_q;
  assign lsu.resp_error = resp_error;
endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed vector table, corner sequences,
// and randomized loads compared against a byte-level reference model.
module tb_load_align_unit;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
`ifdef LOAD_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_align_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) lsu ();
  load_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .lsu(lsu)
  );

  int    n_pass = 0;
  int    n_total = 0;
  string cur_tag = "";

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  msize;
    bit          uns;
    int          wait_cyc;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] exp_data;
    bit          exp_err;
    int          exp_beats;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h, expected %0h", cur_tag, name, act, exp);
  endtask

  // Reference: treat the two beats as a 16-byte little-endian memory window.
  task automatic model(input logic [63:0] addr, input logic [1:0] msize, input bit uns,
                       input logic [63:0] d0, input logic [63:0] d1,
                       output logic [63:0] data, output bit err, output int beats);
    int          size, off;
    byte unsigned mem [16];
    logic [63:0] val;
    size = 1 << msize;
    off  = int'(addr % 64'd8);
    for (int i = 0; i < 8; i++) begin
      mem[i]     = d0[8*i +: 8];
      mem[8 + i] = d1[8*i +: 8];
    end
    if (!SPLIT && (off % size) != 0) begin
      data = 64'h0; err = 1'b1; beats = 0;
      return;
    end
    err   = 1'b0;
    beats = (off + size > 8) ? 2 : 1;
    val   = 64'h0;
    for (int k = 0; k < size; k++) val = val + (64'(mem[off + k]) << (8 * k));
    if (!uns && size < 8 && val[8*size-1]) val = val - (64'd1 << (8 * size));
    data = val;
  endtask

  task automatic run_load(input logic [63:0] addr, input logic [1:0] msize, input bit uns,
                          input int wait_cyc, input logic [63:0] d0, input logic [63:0] d1,
                          output logic [63:0] rdata, output bit rerr, output int beats,
                          output logic [63:0] a0, output logic [63:0] a1, output int lat,
                          output bit stable, output bit busy_ready);
    int          waited;
    logic [63:0] held;
    rdata = 64'h0; rerr = 1'b0; beats = 0; a0 = 64'h0; a1 = 64'h0;
    lat = -1; stable = 1'b1; busy_ready = 1'b0; held = 64'h0;
    for (int i = 0; i < 10 && !lsu.req_ready; i++) @(negedge clk);
    lsu.req_valid    = 1'b1;
    lsu.req_addr     = addr;
    lsu.req_msize    = msize;
    lsu.req_unsigned = uns;
    @(negedge clk);
    lsu.req_valid = 1'b0;
    waited = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (lsu.resp_valid) begin
        rdata = lsu.resp_data;
        rerr  = lsu.resp_error;
        lat   = cyc;
        break;
      end
      if (lsu.req_ready) busy_ready = 1'b1;
      if (lsu.bus_valid) begin
        if (waited == 0) held = lsu.bus_addr;
        else if (lsu.bus_addr !== held) stable = 1'b0;
        if (waited < wait_cyc) waited++;
        else begin
          lsu.bus_ok   = 1'b1;
          lsu.bus_data = (beats == 0) ? d0 : d1;
          if (beats == 0) a0 = held;
          else a1 = held;
          beats++;
          waited = 0;
        end
      end
      @(negedge clk);
      lsu.bus_ok = 1'b0;
    end
  endtask

  task automatic do_vec(input logic [63:0] addr, input logic [1:0] msize, input bit uns,
                        input int wait_cyc, input logic [63:0] d0, input logic [63:0] d1,
                        input logic [63:0] exp_data, input bit exp_err, input int exp_beats);
    logic [63:0] rdata, a0, a1, base;
    bit          rerr, stable, busy_ready;
    int          beats, lat;
    run_load(addr, msize, uns, wait_cyc, d0, d1, rdata, rerr, beats, a0, a1, lat,
             stable, busy_ready);
    base = addr & ~64'h7;
    check("got_resp", 64'(lat > 0), 64'h1);
    check("data", rdata, exp_data);
    check("error", 64'(rerr), 64'(exp_err));
    check("beats", 64'(beats), 64'(exp_beats));
    if (exp_beats >= 1) check("addr0", a0, base);
    if (exp_beats == 2) check("addr1", a1, base + 64'd8);
    check("latency", 64'(lat), exp_err ? 64'd1 : 64'(1 + exp_beats * (1 + wait_cyc)));
    if (wait_cyc > 0 && exp_beats > 0) check("bus_stable", 64'(stable), 64'h1);
    check("ready_busy", 64'(busy_ready), 64'h0);
    @(negedge clk);
    check("pulse_valid", 64'(lsu.resp_valid), 64'h0);
    check("pulse_error", 64'(lsu.resp_error), 64'h0);
    check("data_hold", lsu.resp_data, exp_data);
    check("ready_idle", 64'(lsu.req_ready), 64'h1);
  endtask

  // Drive a stray bus_ok and confirm nothing answers it.
  task automatic stray_ok(input logic [63:0] data);
    bit seen;
    seen = 1'b0;
    lsu.bus_ok   = 1'b1;
    lsu.bus_data = data;
    for (int i = 0; i < 4; i++) begin
      if (lsu.resp_valid || lsu.bus_valid) seen = 1'b1;
      @(negedge clk);
      lsu.bus_ok = 1'b0;
    end
    check("stray_resp", 64'(seen), 64'h0);
    check("stray_ready", 64'(lsu.req_ready), 64'h1);
  endtask

  initial begin
    logic [63:0] addr, d0, d1, edata, r1, a0, a1;
    logic [1:0]  msize;
    bit          uns, eerr, rerr, st, br;
    int          ebeats, w, beats, lat;

    lsu.req_valid = 1'b0; lsu.req_addr = 64'h0; lsu.req_msize = 2'd0;
    lsu.req_unsigned = 1'b0; lsu.bus_ok = 1'b0; lsu.bus_data = 64'h0;
    repeat (2) @(negedge clk);

    cur_tag = "reset";
    check("req_ready", 64'(lsu.req_ready), 64'h1);
    check("bus_valid", 64'(lsu.bus_valid), 64'h0);
    check("bus_addr", lsu.bus_addr, 64'h0);
    check("resp_valid", 64'(lsu.resp_valid), 64'h0);
    check("resp_data", lsu.resp_data, 64'h0);
    check("resp_error", 64'(lsu.resp_error), 64'h0);
    reset = 1'b1;
    @(negedge clk);

    vecs.push_back('{64'h1003, 2'd0, 1'b0, 0, 64'h00000000_80000000, 64'h0,
                     64'hFFFFFFFF_FFFFFF80, 1'b0, 1});
    vecs.push_back('{64'h1004, 2'd2, 1'b1, 3, 64'hDEADBEEF_12345678, 64'h0,
                     64'h00000000_DEADBEEF, 1'b0, 1});
    vecs.push_back('{64'h1006, 2'd2, 1'b0, 0, 64'hABCD0000_00000000, 64'h00000000_0000F123,
                     SPLIT ? 64'hFFFFFFFF_F123ABCD : 64'h0, !SPLIT, SPLIT ? 2 : 0});
    vecs.push_back('{64'h1001, 2'd1, 1'b0, 1, 64'h00000000_00A5B6C7, 64'h0,
                     SPLIT ? 64'hFFFFFFFF_FFFFA5B6 : 64'h0, !SPLIT, SPLIT ? 1 : 0});
    vecs.push_back('{64'h2000, 2'd3, 1'b0, 0, 64'h81234567_89ABCDEF, 64'h0,
                     64'h81234567_89ABCDEF, 1'b0, 1});
    vecs.push_back('{64'h2006, 2'd1, 1'b0, 2, 64'h7FFF0000_00000000, 64'h0,
                     64'h7FFF, 1'b0, 1});
    vecs.push_back('{64'h2002, 2'd1, 1'b1, 0, 64'h00000000_80010000, 64'h0,
                     64'h8001, 1'b0, 1});
    vecs.push_back('{64'h3004, 2'd2, 1'b0, 0, 64'h80000001_00000000, 64'h0,
                     64'hFFFFFFFF_80000001, 1'b0, 1});
    vecs.push_back('{64'hFFFFFFFF_FFFFFFFC, 2'd3, 1'b0, 1, 64'h11223344_55667788,
                     64'h00000000_99AABBCC, SPLIT ? 64'h99AABBCC_11223344 : 64'h0,
                     !SPLIT, SPLIT ? 2 : 0});
    vecs.push_back('{64'h1007, 2'd0, 1'b1, 0, 64'hFE000000_00000000, 64'h0,
                     64'hFE, 1'b0, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      cur_tag = $sformatf("vec%0d", i);
      do_vec(vecs[i].addr, vecs[i].msize, vecs[i].uns, vecs[i].wait_cyc, vecs[i].d0,
             vecs[i].d1, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_beats);
    end

    cur_tag = "idle_bus_ok";
    stray_ok(64'h12345678_9ABCDEF0);

    cur_tag = "reset_mid";
    lsu.req_valid = 1'b1; lsu.req_addr = 64'h4000; lsu.req_msize = 2'd2;
    lsu.req_unsigned = 1'b1;
    @(negedge clk);
    lsu.req_valid = 1'b0;
    check("in_beat", 64'(lsu.bus_valid), 64'h1);
    reset = 1'b0;
    #1;
    check("ready_async", 64'(lsu.req_ready), 64'h1);
    check("bus_valid_async", 64'(lsu.bus_valid), 64'h0);
    @(negedge clk);
    check("ready_next", 64'(lsu.req_ready), 64'h1);
    check("bus_valid_next", 64'(lsu.bus_valid), 64'h0);
    reset = 1'b1;
    @(negedge clk);
    stray_ok(64'hFFFFFFFF_FFFFFFFF);

    cur_tag = "back2back";
    run_load(64'h5008, 2'd2, 1'b0, 0, 64'h00000000_FFFFFFFE, 64'h0, r1, rerr, beats, a0, a1,
             lat, st, br);
    check("first_data", r1, 64'hFFFFFFFF_FFFFFFFE);
    run_load(64'h5010, 2'd0, 1'b1, 0, 64'h00000000_000000AA, 64'h0, r1, rerr, beats, a0, a1,
             lat, st, br);
    check("second_data", r1, 64'hAA);
    check("second_latency", 64'(lat), 64'd2);
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      addr  = {$urandom, $urandom};
      msize = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      w     = int'($urandom_range(0, 2));
      d0    = {$urandom, $urandom};
      d1    = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) addr = addr & ~((64'd1 << msize) - 64'd1);
      model(addr, msize, uns, d0, d1, edata, eerr, ebeats);
      do_vec(addr, msize, uns, w, d0, d1, edata, eerr, ebeats);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "time limit");
  end
endmodule
